// File: rtl/dpram_rd_streamer.sv
// Streams num_words consecutive words from a dual-port RAM read port into a
// ready/valid interface through a small FIFO. Stall counter: DPRAM_RD_STALL_CNT_EN.
module dpram_rd_streamer #(
  parameter int DW         = 64,
  parameter int AW         = 8,
  parameter int N_DELAY    = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   num_words,
  output logic          busy,
  output logic          done,
  output logic          enb,
  output logic [AW-1:0] addrb,
  input  logic [DW-1:0] dob,
  output logic [DW-1:0] m_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic          m_last,
  output logic [31:0]   stall_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state, state_n;

  logic [AW:0]        nw, issued, sent;
  logic [N_DELAY-1:0] tag;
  logic [CW-1:0]      inflight, fifo_cnt;
  logic [PW-1:0]      wptr, rptr;
  logic [DW-1:0]      mem [FIFO_DEPTH];
  logic               accept, issue, wr, pop;

  assign accept  = (state == IDLE) && start;
  assign wr      = enb && tag[N_DELAY-1];
  assign m_valid = (fifo_cnt != '0);
  assign m_data  = mem[rptr];
  assign pop     = m_valid && m_ready;
  assign m_last  = m_valid && (sent == nw - (AW+1)'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Reads are only issued while the FIFO can still absorb every in-flight word
  always_comb begin
    state_n = state;
    enb     = 1'b0;
    done    = 1'b0;
    issue   = 1'b0;
    busy    = (state != IDLE);
    unique case (state)
      IDLE:  if (start) state_n = (num_words == '0) ? DONE : RUN;
      RUN: begin
        enb   = 1'b1;
        issue = (issued < nw) && (({1'b0, fifo_cnt} + {1'b0, inflight}) < DEPTH_C);
        if (issued == nw) state_n = DRAIN;
      end
      DRAIN: begin
        enb = 1'b1;
        if (pop && m_last && (inflight == '0)) state_n = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addrb    <= '0;
      nw       <= '0;
      issued   <= '0;
      sent     <= '0;
      tag      <= '0;
      inflight <= '0;
      fifo_cnt <= '0;
      wptr     <= '0;
      rptr     <= '0;
      for (int unsigned i = 0; i < 32'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        addrb  <= base_addr;
        nw     <= num_words;
        issued <= '0;
      end else if (issue) begin
        addrb  <= addrb + AW'(1);
        issued <= issued + (AW+1)'(1);
      end
      if (accept)   sent <= '0;
      else if (pop) sent <= sent + (AW+1)'(1);
      // Tag line moves in lockstep with the RAM delay line, which only advances on enb
      if (enb) begin
        tag[0] <= issue;
        for (int unsigned i = 1; i < 32'(N_DELAY); i++) tag[i] <= tag[i-1];
      end
      inflight <= inflight + CW'(issue) - CW'(wr);
      if (wr) begin
        mem[wptr] <= dob;
        wptr      <= wptr + PW'(1);
      end
      if (pop) rptr <= rptr + PW'(1);
      fifo_cnt <= fifo_cnt + CW'(wr) - CW'(pop);
    end
  end

`ifdef DPRAM_RD_STALL_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                          stall_cnt <= '0;
    else if (accept)                                  stall_cnt <= '0;
    else if (m_valid && !m_ready && stall_cnt != '1)  stall_cnt <= stall_cnt + 32'd1;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: doc/dpram_rd_streamer.md
DPRAM_RD_STREAMER -- requirements
Module: dpram_rd_streamer

Interface
REQ-001 Parameter DW, default 64, data bit-width per word; SHALL match the attached dual-port RAM.
REQ-002 Parameter AW, default 8, RAM address bit-width.
REQ-003 Parameter N_DELAY, default 1, RAM read latency in enb-high cycles; SHALL be >= 1.
REQ-004 Parameter FIFO_DEPTH, default 4, output FIFO depth; SHALL be >= 2, power of two.
REQ-005 clk  input  1  single clock; all logic SHALL be rising-edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 start  input  1  one-cycle request, sampled only in IDLE.
REQ-008 base_addr  input  AW  first RAM word address, captured on accepted start.
REQ-009 num_words  input  AW+1  word count, captured on accepted start; 0 is legal.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 done  output  1  one-cycle pulse after the last word is accepted downstream.
REQ-012 enb  output  1  RAM read-port enable.
REQ-013 addrb  output  AW  RAM read address.
REQ-014 dob  input  DW  RAM read data, valid N_DELAY enb-high cycles after issue.
REQ-015 m_data  output  DW  stream data, taken from the FIFO head.
REQ-016 m_valid  output  1  stream valid.
REQ-017 m_ready  input  1  stream ready; a transfer occurs on m_valid & m_ready.
REQ-018 m_last  output  1  high with the final word of the job.
REQ-019 stall_cnt  output  32  stall counter (see Configuration).

Function
REQ-020 FSM SHALL have states IDLE, RUN, DRAIN and DONE: IDLE->RUN on start with num_words!=0; IDLE->DONE on start with num_words==0; RUN->DRAIN when the issue count equals num_words; DRAIN->DONE when the in-flight count is 0, the FIFO is empty and the final transfer has completed; DONE->IDLE unconditionally after one cycle.
REQ-021 enb SHALL be held at 1 throughout RUN and DRAIN and at 0 in IDLE and DONE, because the RAM delay line advances only while enb is high.
REQ-022 A read SHALL be issued in RUN when (issued < num_words) and (fifo_count + inflight) < FIFO_DEPTH; addrb SHALL then increment by 1 in the next cycle.
REQ-023 addrb SHALL wrap modulo 2^AW (for example, 0xFF+1 gives 0x00 when AW=8).
REQ-024 An N_DELAY-deep valid shift register, advanced every enb-high cycle, SHALL tag each issued read; dob SHALL be written to the FIFO when the tag exits the register.
REQ-025 Latency: with start accepted at cycle T, the first issue SHALL occur at T+1 and m_valid SHALL first rise at T+2+N_DELAY.
REQ-026 When FIFO_DEPTH >= N_DELAY+2 and m_ready is held at 1, one word per cycle SHALL be sustained.
REQ-027 The FIFO SHALL never overflow; it SHALL accept a simultaneous write and read while full, and it SHALL NOT bypass an empty FIFO (m_data is registered).
REQ-028 m_valid SHALL NOT drop until a transfer occurs, and m_data SHALL remain stable while m_valid & !m_ready.
REQ-029 start SHALL be ignored while busy is high.
REQ-030 done SHALL pulse exactly once per accepted start, including when num_words==0; it SHALL coincide with the DONE state.

Reset
REQ-031 When rst is asserted, the block SHALL asynchronously clear: FSM to IDLE; busy, done, enb, m_valid, m_last to 0; addrb and m_data to 0; FIFO pointers, issue, in-flight and tag registers to 0; stall_cnt to 0.
REQ-032 If rst is asserted mid-job, the job SHALL be abandoned with no done pulse, and RAM data returning after reset release SHALL be discarded.

Configuration
REQ-033 Macro DPRAM_RD_STALL_CNT_EN: when defined, stall_cnt SHALL increment (saturating at 0xFFFFFFFF) on every cycle with m_valid & !m_ready and SHALL clear on each accepted start; when undefined, stall_cnt SHALL be tied to 0 and no counter logic SHALL be present.

Verification
REQ-034 N_DELAY=1, base_addr=0x10, num_words=4, m_ready=1 -> addrb issues 0x10..0x13 at T+1..T+4; m_data equals RAM[0x10..0x13] at T+3..T+6; m_last at T+6; done at T+7.
REQ-035 base_addr=0xFE, num_words=4 -> addrb sequence is 0xFE, 0xFF, 0x00, 0x01 and the data order matches.
REQ-036 num_words=0 -> enb never asserts, m_valid stays 0, done pulses at T+1, and busy is high for one cycle.
REQ-037 N_DELAY=3, FIFO_DEPTH=4, num_words=16, m_ready low for 10 cycles after the first valid -> no lost or duplicated words; issuing stops at fifo_count+inflight=4; with DPRAM_RD_STALL_CNT_EN defined, stall_cnt=10.
REQ-038 rst asserted 3 cycles into an 8-word job -> all outputs are 0 immediately; after release no m_valid and no done appear; a new start then behaves as in REQ-034.
REQ-039 start pulsed again during RUN -> ignored; exactly num_words transfers occur and done pulses once.
